// File: rtl/nerv_wb_pkg.sv
// Shared types and constants for the nerv data-memory Wishbone bridge.
//   bridge_state_e : bridge FSM states (IDLE, BUS, DONE)
//   SEL_ALL        : byte select used for reads (all four lanes)
//   TIMEOUT_RDATA  : read data returned to the core when a bus cycle is aborted
package nerv_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } bridge_state_e;

   localparam logic [3:0]  SEL_ALL       = 4'hF;
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent in a Wishbone bus cycle and flags expiry.
// Only instantiated when NERV_WB_BRIDGE_TIMEOUT_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : return the count to zero (held while not in a bus cycle)
//   i_enable   : count this cycle (bus cycle in progress)
//   o_expired  : high during the TIMEOUT_CYCLES-th enabled cycle
module bus_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   // Count is 0 in the first enabled cycle, so the last one sits at TIMEOUT_CYCLES-1.
   localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LastCnt)) begin
         r_count <= r_count + CntW'(1);
      end
   end

   assign o_expired = i_enable && (r_count == LastCnt);

endmodule

// File: rtl/nerv_wb_dmem_bridge.sv
// Bridges the nerv core's fixed-latency data port onto a Wishbone-classic master.
// The core is stalled while a bus cycle is outstanding; read data is presented in
// the DONE cycle, when stall drops.
// Optional feature: define NERV_WB_BRIDGE_TIMEOUT_EN to abort bus cycles that get
// no ack within TIMEOUT_CYCLES (returns TIMEOUT_RDATA for reads, pulses err_o).
//   clk, rst_n       : clock, asynchronous active-low reset
//   dmem_*           : core request (valid/addr/wstrb/wdata) and read data
//   stall_o          : core stall
//   err_o            : one-cycle bus-timeout pulse (tied low without the macro)
//   data_mem_*       : Wishbone-classic master towards the Controller
module nerv_wb_dmem_bridge
   import nerv_wb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dmem_valid_i,
   input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
   input  logic [3:0]            dmem_wstrb_i,
   input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
   output logic [DATA_WIDTH-1:0] dmem_rdata_o,
   output logic                  stall_o,
   output logic                  err_o,
   output logic                  data_mem_cyc_o,
   output logic                  data_mem_stb_o,
   output logic                  data_mem_we_o,
   output logic [3:0]            data_mem_sel_o,
   output logic [ADDR_WIDTH-1:0] data_mem_addr_o,
   output logic [DATA_WIDTH-1:0] data_mem_data_o,
   input  logic [DATA_WIDTH-1:0] data_mem_data_i,
   input  logic                  data_mem_ack_i
);

   bridge_state_e         r_state;
   bridge_state_e         w_state_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [3:0]            r_sel;
   logic                  r_we;
   logic                  r_cyc;
   logic                  w_in_bus;
   logic                  w_accept;
   logic                  w_ack;
   logic                  w_timeout;
   logic [1:0]            w_unused_addr_lsb;

   assign w_in_bus = (r_state == BUS);
   assign w_accept = (r_state == IDLE) && dmem_valid_i;
   // Acks outside BUS are spurious and must not move the FSM or the read data.
   assign w_ack    = w_in_bus && data_mem_ack_i;
   assign w_unused_addr_lsb = dmem_addr_i[1:0];

`ifdef NERV_WB_BRIDGE_TIMEOUT_EN
   logic w_expired;
   logic r_err;

   bus_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (!w_in_bus),
      .i_enable (w_in_bus),
      .o_expired(w_expired)
   );

   // An ack in the expiry cycle wins over the timeout.
   assign w_timeout = w_in_bus && w_expired && !data_mem_ack_i;

   // Registered so the pulse lands in the DONE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_timeout;
      end
   end

   assign err_o = r_err;
`else
   logic w_unused_timeout;

   assign w_timeout        = 1'b0;
   assign err_o            = 1'b0;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; a valid seen in DONE is the request just served.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (dmem_valid_i) w_state_next = BUS;
         BUS:     if (w_ack || w_timeout) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Outputs: stall rises combinationally in the accepting IDLE cycle.
   always_comb begin
      stall_o = 1'b0;
      case (r_state)
         IDLE:    stall_o = dmem_valid_i;
         BUS:     stall_o = 1'b1;
         default: stall_o = 1'b0;
      endcase
   end

   // Request latches, bus cycle flag and read-data register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_sel   <= '0;
         r_we    <= 1'b0;
         r_cyc   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr  <= {dmem_addr_i[ADDR_WIDTH-1:2], 2'b00};
            r_wdata <= dmem_wdata_i;
            r_we    <= |dmem_wstrb_i;
            r_sel   <= (|dmem_wstrb_i) ? dmem_wstrb_i : SEL_ALL;
            r_cyc   <= 1'b1;
         end else if (w_ack || w_timeout) begin
            r_cyc   <= 1'b0;
         end

         if (w_ack && !r_we) begin
            r_rdata <= data_mem_data_i;
         end else if (w_timeout && !r_we) begin
            r_rdata <= DATA_WIDTH'(TIMEOUT_RDATA);
         end
      end
   end

   assign dmem_rdata_o    = r_rdata;
   assign data_mem_cyc_o  = r_cyc;
   assign data_mem_stb_o  = r_cyc;
   assign data_mem_we_o   = r_we;
   assign data_mem_sel_o  = r_sel;
   assign data_mem_addr_o = r_addr;
   assign data_mem_data_o = r_wdata;

endmodule

// File: tb/tb_nerv_wb_dmem_bridge.sv
// Scoreboard bench for nerv_wb_dmem_bridge. Stimulus pushes the expected bus
// request and core response; a monitor pops and compares when a bus cycle starts
// and when stall releases (DONE cycle). Timeout cases run only when
// NERV_WB_BRIDGE_TIMEOUT_EN is defined.
module tb_nerv_wb_dmem_bridge;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] data;
      int          gap;   // cycles from previous ack to cyc rise, -1 = don't care
   } bus_exp_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      int          stall_len;
      int          cyc_len;
   } rsp_exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dmem_valid_i = 1'b0;
   logic [31:0] dmem_addr_i = '0;
   logic [3:0]  dmem_wstrb_i = '0;
   logic [31:0] dmem_wdata_i = '0;
   logic [31:0] dmem_rdata_o;
   logic        stall_o;
   logic        err_o;
   logic        data_mem_cyc_o;
   logic        data_mem_stb_o;
   logic        data_mem_we_o;
   logic [3:0]  data_mem_sel_o;
   logic [31:0] data_mem_addr_o;
   logic [31:0] data_mem_data_o;
   logic [31:0] data_mem_data_i = '0;
   logic        data_mem_ack_i = 1'b0;

   bus_exp_t bus_q[$];
   rsp_exp_t rsp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   int          ack_k = 0;       // ack in the k-th cycle of cyc; 0 = never
   logic        spurious = 1'b0;
   logic [31:0] mem_rdata = '0;
   int          bus_cnt = 0;
   int          cyc_num = 0;

   nerv_wb_dmem_bridge #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .dmem_valid_i   (dmem_valid_i),
      .dmem_addr_i    (dmem_addr_i),
      .dmem_wstrb_i   (dmem_wstrb_i),
      .dmem_wdata_i   (dmem_wdata_i),
      .dmem_rdata_o   (dmem_rdata_o),
      .stall_o        (stall_o),
      .err_o          (err_o),
      .data_mem_cyc_o (data_mem_cyc_o),
      .data_mem_stb_o (data_mem_stb_o),
      .data_mem_we_o  (data_mem_we_o),
      .data_mem_sel_o (data_mem_sel_o),
      .data_mem_addr_o(data_mem_addr_o),
      .data_mem_data_o(data_mem_data_o),
      .data_mem_data_i(data_mem_data_i),
      .data_mem_ack_i (data_mem_ack_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_num <= cyc_num + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   function automatic bus_exp_t mk_bus(input logic [31:0] a, input logic [3:0] s, input logic w,
                                       input logic [31:0] d, input int g);
      bus_exp_t b;
      b.addr = a; b.sel = s; b.we = w; b.data = d; b.gap = g;
      return b;
   endfunction

   function automatic rsp_exp_t mk_rsp(input logic [31:0] r, input logic e, input int sl,
                                       input int cl);
      rsp_exp_t x;
      x.rdata = r; x.err = e; x.stall_len = sl; x.cyc_len = cl;
      return x;
   endfunction

   // Memory: acks the ack_k-th cycle of cyc; data bus carries garbage otherwise.
   always begin
      @(posedge clk);
      #1;
      if (rst_n && data_mem_cyc_o && data_mem_stb_o) begin
         bus_cnt++;
         data_mem_ack_i = (ack_k != 0) && (bus_cnt == ack_k);
      end else begin
         bus_cnt = 0;
         data_mem_ack_i = spurious;
      end
      data_mem_data_i = data_mem_ack_i ? mem_rdata : ~mem_rdata;
   end

   // Monitor
   logic prev_cyc = 1'b0;
   logic prev_stall = 1'b0;
   int   stall_run = 0;
   int   cyc_run = 0;
   int   last_ack = -1;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_cyc = 1'b0; prev_stall = 1'b0; stall_run = 0; cyc_run = 0;
      end else begin
         check("stb_eq_cyc", 32'(data_mem_stb_o), 32'(data_mem_cyc_o));
         if (data_mem_cyc_o && !prev_cyc) begin
            if (bus_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL bus_unexpected: got txn addr %08h, expected none", data_mem_addr_o);
            end else begin
               bus_exp_t b;
               b = bus_q.pop_front();
               check("bus_addr", data_mem_addr_o, b.addr);
               check("bus_sel", 32'(data_mem_sel_o), 32'(b.sel));
               check("bus_we", 32'(data_mem_we_o), 32'(b.we));
               check("bus_data", data_mem_data_o, b.data);
               if (b.gap >= 0) check("b2b_gap", 32'(cyc_num - last_ack), 32'(b.gap));
            end
         end
         if (data_mem_cyc_o) cyc_run++;
         if (data_mem_cyc_o && data_mem_ack_i) last_ack = cyc_num;
         if (stall_o) stall_run++;
         if (prev_stall && !stall_o) begin
            if (rsp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL rsp_unexpected: got stall release, expected none");
            end else begin
               rsp_exp_t r;
               r = rsp_q.pop_front();
               check("rsp_rdata", dmem_rdata_o, r.rdata);
               check("rsp_err", 32'(err_o), 32'(r.err));
               check("rsp_stall_len", 32'(stall_run), 32'(r.stall_len));
               check("rsp_cyc_len", 32'(cyc_run), 32'(r.cyc_len));
            end
            stall_run = 0;
            cyc_run = 0;
         end else begin
            check("err_outside_done", 32'(err_o), 32'h0);
         end
         prev_cyc = data_mem_cyc_o;
         prev_stall = stall_o;
      end
   end

   // Core model: hold the request through stall and the DONE cycle, then drop it.
   task automatic core_req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                           input logic [31:0] md, input int k, input bus_exp_t be,
                           input rsp_exp_t re);
      int n;
      bus_q.push_back(be);
      rsp_q.push_back(re);
      mem_rdata = md;
      ack_k = k;
      dmem_addr_i = a; dmem_wstrb_i = s; dmem_wdata_i = d; dmem_valid_i = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (stall_o && n < 64);
      if (stall_o) begin
         n_checks++; n_errors++;
         $display("FAIL req_wait: stall still high after %0d cycles, expected release", n);
      end
      @(posedge clk);
      #1;
      dmem_valid_i = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cyc"}, 32'(data_mem_cyc_o), 32'h0);
      check({tag, "_stb"}, 32'(data_mem_stb_o), 32'h0);
      check({tag, "_we"}, 32'(data_mem_we_o), 32'h0);
      check({tag, "_sel"}, 32'(data_mem_sel_o), 32'h0);
      check({tag, "_addr"}, data_mem_addr_o, 32'h0);
      check({tag, "_data"}, data_mem_data_o, 32'h0);
      check({tag, "_rdata"}, dmem_rdata_o, 32'h0);
      check({tag, "_stall"}, 32'(stall_o), 32'h0);
      check({tag, "_err"}, 32'(err_o), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #10;
      check_all_zero("reset");
      #7 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Read, ack in the first bus cycle
      core_req(32'h0000_1006, 4'h0, 32'h0, 32'h1234_5678, 1,
               mk_bus(32'h0000_1004, 4'hF, 1'b0, 32'h0, -1),
               mk_rsp(32'h1234_5678, 1'b0, 2, 1));
      // Byte write, ack in cycle 5; read data must not change
      core_req(32'h0000_2002, 4'b0100, 32'hAABB_CCDD, 32'h5A5A_5A5A, 5,
               mk_bus(32'h0000_2000, 4'b0100, 1'b1, 32'hAABB_CCDD, -1),
               mk_rsp(32'h1234_5678, 1'b0, 6, 5));
      // Back-to-back read then write: cyc re-rises 3 cycles after the ack cycle
      core_req(32'h0000_3008, 4'h0, 32'h0, 32'hCAFE_F00D, 2,
               mk_bus(32'h0000_3008, 4'hF, 1'b0, 32'h0, -1),
               mk_rsp(32'hCAFE_F00D, 1'b0, 3, 2));
      core_req(32'h0000_400F, 4'b1001, 32'h1122_3344, 32'h5A5A_5A5A, 1,
               mk_bus(32'h0000_400C, 4'b1001, 1'b1, 32'h1122_3344, 3),
               mk_rsp(32'hCAFE_F00D, 1'b0, 2, 1));

      // Spurious ack while idle
      spurious = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      check("spur_cyc", 32'(data_mem_cyc_o), 32'h0);
      check("spur_stall", 32'(stall_o), 32'h0);
      check("spur_rdata", dmem_rdata_o, 32'hCAFE_F00D);
      check("spur_err", 32'(err_o), 32'h0);
      spurious = 1'b0;
      @(posedge clk);
      #1;

      // Reset asserted while the bus cycle waits for an ack that never comes
      bus_q.push_back(mk_bus(32'h0000_5000, 4'hF, 1'b0, 32'h0, -1));
      mem_rdata = 32'h0; ack_k = 0;
      dmem_addr_i = 32'h0000_5000; dmem_wstrb_i = 4'h0; dmem_wdata_i = 32'h0;
      dmem_valid_i = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("mid_cyc_before_rst", 32'(data_mem_cyc_o), 32'h1);
      #2;
      dmem_valid_i = 1'b0;
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_rst");
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Normal operation after reset
      core_req(32'h0000_6004, 4'h0, 32'h0, 32'h0BAD_F00D, 3,
               mk_bus(32'h0000_6004, 4'hF, 1'b0, 32'h0, -1),
               mk_rsp(32'h0BAD_F00D, 1'b0, 4, 3));

`ifdef NERV_WB_BRIDGE_TIMEOUT_EN
      // Timeout after 8 bus cycles: read gets DEADBEEF, err in DONE
      core_req(32'h0000_7000, 4'h0, 32'h0, 32'h1111_1111, 0,
               mk_bus(32'h0000_7000, 4'hF, 1'b0, 32'h0, -1),
               mk_rsp(32'hDEAD_BEEF, 1'b1, 9, 8));
      // Write timeout leaves read data alone
      core_req(32'h0000_7004, 4'hF, 32'h0000_0055, 32'h2222_2222, 0,
               mk_bus(32'h0000_7004, 4'hF, 1'b1, 32'h0000_0055, -1),
               mk_rsp(32'hDEAD_BEEF, 1'b1, 9, 8));
      // Ack in the expiry cycle wins
      core_req(32'h0000_7008, 4'h0, 32'h0, 32'h600D_DA7A, 8,
               mk_bus(32'h0000_7008, 4'hF, 1'b0, 32'h0, -1),
               mk_rsp(32'h600D_DA7A, 1'b0, 9, 8));
`endif

      repeat (5) begin @(posedge clk); #1; end
      check("bus_q_drained", 32'(bus_q.size()), 32'h0);
      check("rsp_q_drained", 32'(rsp_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
